mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between a fetch port, a data port and the shared unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_f3;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic              d_err;
  logic              mem_rd;
  logic              mem_wr;
  logic [2:0]        mem_f3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, d_gnt, d_rvalid, d_err,
           mem_rd, mem_wr, mem_f3, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, d_gnt, d_rvalid, d_err,
           mem_rd, mem_wr, mem_f3, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one unified memory; data wins
// contention until MAX_D_RUN consecutive wins, then fetch is forced through once.
module mem_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int MAX_D_RUN = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int CNT_W = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_D_RUN);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;

  logic              contested, fetch_forced, misaligned;
  logic              if_gnt, d_gnt, d_ok;
  logic              mem_rd, mem_wr;
  logic [2:0]        f3_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // Grants are gated by rst so nothing reaches memory while reset is held.
  always_comb begin
    contested    = bus.if_req & bus.d_req;
    fetch_forced = contested & (run_cnt_reg == RUN_MAX);
    if_gnt       = ~rst & bus.if_req & (~bus.d_req | fetch_forced);
    d_gnt        = ~rst & bus.d_req & ~fetch_forced;
    misaligned   = ((bus.d_f3[1:0] == 2'b01) & bus.d_addr[0]) |
                   ((bus.d_f3[1:0] == 2'b10) & (bus.d_addr[1:0] != 2'b00));
    d_ok         = d_gnt & ~misaligned;
  end

  always_comb begin
    mem_rd    = if_gnt | (d_ok & ~bus.d_we);
    mem_wr    = d_ok & bus.d_we;
    f3_mux    = 3'b000;
    addr_mux  = '0;
    wdata_mux = '0;
    if (if_gnt) begin
      f3_mux   = 3'b010;
      addr_mux = bus.if_addr;
    end else if (d_gnt) begin
      f3_mux    = bus.d_f3;
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
    end
  end

  always_comb begin
    run_cnt_next = '0;
    if (contested & d_gnt)
      run_cnt_next = (run_cnt_reg == RUN_MAX) ? RUN_MAX : run_cnt_reg + CNT_W'(1);
  end

  // State register: owner of the read response arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      run_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (if_gnt)
      state_next = RESP_IF;
    else if (d_ok & ~bus.d_we)
      state_next = RESP_D;
  end

  always_comb begin
    bus.if_rvalid = ~rst & (state_reg == RESP_IF);
    bus.d_rvalid  = ~rst & (state_reg == RESP_D);
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_err     = d_gnt & misaligned;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_f3    = f3_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.stall     = (bus.if_req & ~if_gnt) | (bus.d_req & ~d_gnt);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle model
// that tracks the data win streak and which port owes a read response.
module tb_mem_port_arbiter;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int d_run  = 0;
  bit pend_if = 0, pend_d = 0;
  bit g_if = 0, g_d_load = 0, g_contested_d = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic settle();
    bit e_if_gnt, e_d_gnt, e_err, e_rd, e_wr, e_if_rv, e_d_rv, e_stall;
    bit contested, mis;
    int sz;
    logic [2:0]    e_f3;
    logic [AW-1:0] e_addr;
    @(negedge clk);
    e_if_gnt = 0; e_d_gnt = 0; e_err = 0; e_rd = 0; e_wr = 0;
    e_if_rv = 0; e_d_rv = 0; e_f3 = 3'b000; e_addr = '0;
    contested = bus.if_req && bus.d_req;
    sz = 1 << bus.d_f3[1:0];
    mis = (sz == 2 || sz == 4) && ((int'(bus.d_addr) % sz) != 0);
    if (!rst) begin
      e_if_rv = pend_if;
      e_d_rv  = pend_d;
      if (contested) begin
        if (d_run >= MAX) e_if_gnt = 1; else e_d_gnt = 1;
      end else begin
        e_if_gnt = bus.if_req;
        e_d_gnt  = bus.d_req;
      end
      if (e_if_gnt) begin
        e_rd = 1; e_f3 = 3'b010; e_addr = bus.if_addr;
      end
      if (e_d_gnt) begin
        e_err = mis;
        e_rd  = !mis && !bus.d_we;
        e_wr  = !mis && bus.d_we;
        e_f3  = bus.d_f3;
        e_addr = bus.d_addr;
      end
    end
    e_stall = (bus.if_req && !e_if_gnt) || (bus.d_req && !e_d_gnt);
    check("if_gnt", bus.if_gnt, e_if_gnt);
    check("d_gnt", bus.d_gnt, e_d_gnt);
    check("d_err", bus.d_err, e_err);
    check("mem_rd", bus.mem_rd, e_rd);
    check("mem_wr", bus.mem_wr, e_wr);
    check("if_rvalid", bus.if_rvalid, e_if_rv);
    check("d_rvalid", bus.d_rvalid, e_d_rv);
    check("stall", bus.stall, e_stall);
    if (e_if_gnt || e_d_gnt) begin
      check("mem_f3", bus.mem_f3, e_f3);
      check("mem_addr", bus.mem_addr, e_addr);
    end
    if (e_d_gnt) check("mem_wdata", bus.mem_wdata, bus.d_wdata);
    g_if          = e_if_gnt;
    g_d_load      = e_d_gnt && !mis && !bus.d_we;
    g_contested_d = contested && e_d_gnt;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      d_run = 0; pend_if = 0; pend_d = 0;
    end else begin
      pend_if = g_if;
      pend_d  = g_d_load;
      d_run   = g_contested_d ? ((d_run + 1 > MAX) ? MAX : d_run + 1) : 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_f3 = 3'b010; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    // Reset held with both ports requesting
    bus.if_req = 1; bus.d_req = 1; bus.d_addr = 6'h04;
    rst = 1;
    repeat (2) begin
      settle();
      check("reset_if_gnt", bus.if_gnt, 1'b0);
      check("reset_d_gnt", bus.d_gnt, 1'b0);
      advance();
    end
    rst = 0;
    idle_inputs();
    settle(); advance();

    // Fetch only
    bus.if_req = 1; bus.if_addr = 6'h04;
    settle();
    check("fetch_gnt", bus.if_gnt, 1'b1);
    check("fetch_addr", bus.mem_addr, 6'h04);
    check("fetch_f3", bus.mem_f3, 3'b010);
    advance();
    idle_inputs();
    settle();
    check("fetch_rvalid", bus.if_rvalid, 1'b1);
    advance();

    // Contention: three data grants then one fetch, repeating
    bus.if_req = 1; bus.if_addr = 6'h10;
    bus.d_req = 1; bus.d_we = 0; bus.d_f3 = 3'b010; bus.d_addr = 6'h20;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("cont_d_gnt", bus.d_gnt, (k % 4) != 3);
      check("cont_if_gnt", bus.if_gnt, (k % 4) == 3);
      check("cont_stall", bus.stall, 1'b1);
      advance();
    end
    idle_inputs();
    settle(); advance();

    // Store
    bus.d_req = 1; bus.d_we = 1; bus.d_f3 = 3'b010; bus.d_addr = 6'h08; bus.d_wdata = 32'hDEADBEEF;
    settle();
    check("store_wr", bus.mem_wr, 1'b1);
    check("store_rd", bus.mem_rd, 1'b0);
    check("store_addr", bus.mem_addr, 6'h08);
    check("store_wdata", bus.mem_wdata, 32'hDEADBEEF);
    advance();
    idle_inputs();
    settle();
    check("store_no_rvalid", bus.d_rvalid, 1'b0);
    advance();

    // Misaligned word load
    bus.d_req = 1; bus.d_we = 0; bus.d_f3 = 3'b010; bus.d_addr = 6'h06;
    settle();
    check("mis_gnt", bus.d_gnt, 1'b1);
    check("mis_err", bus.d_err, 1'b1);
    check("mis_rd", bus.mem_rd, 1'b0);
    advance();
    idle_inputs();
    settle();
    check("mis_no_rvalid", bus.d_rvalid, 1'b0);
    advance();

    // Reset mid-operation discards the pending load response
    bus.d_req = 1; bus.d_we = 0; bus.d_f3 = 3'b010; bus.d_addr = 6'h10;
    settle();
    check("rst_load_gnt", bus.d_gnt, 1'b1);
    advance();
    rst = 1;
    settle();
    check("rst_d_rvalid", bus.d_rvalid, 1'b0);
    check("rst_d_gnt", bus.d_gnt, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    advance();
    rst = 0;
    settle();
    check("post_rst_gnt", bus.d_gnt, 1'b1);
    check("post_rst_rvalid", bus.d_rvalid, 1'b0);
    advance();

    // Randomized traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      bus.if_req    = ($urandom_range(0, 3) != 0);
      bus.if_addr   = AW'($urandom);
      bus.d_req     = ($urandom_range(0, 3) != 0);
      bus.d_we      = $urandom_range(0, 1);
      bus.d_f3      = 3'($urandom);
      bus.d_addr    = AW'($urandom);
      bus.d_wdata   = $urandom;
      bus.mem_rdata = $urandom;
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
